regfile_sb: RTL and testbench

Parametrised multi-read-port register file with a per-register pending-write scoreboard, write-before-read bypass, a hardwired-zero register 0, and a sequential bulk-clear engine. It sits in the decode stage of the pipelined core and replaces the fixed 16x16, two-read-port register file. Decode uses `rd_busy` for stall decisions. Writeback drives the write port.

---
 rtl/regfile_sb.sv | 73 +++++++
 tb/tb_regfile_sb.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
// regfile_sb: multi-read-port register file with pending-write scoreboard, write bypass and bulk clear
module regfile_sb #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 4,
   parameter int NRD    = 2
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [NRD*ADDR_W-1:0] rd_addr,
   output logic [NRD*DATA_W-1:0] rd_data,
   output logic [NRD-1:0]        rd_busy,
   input  logic                  wr_en,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [DATA_W-1:0]     wr_data,
   input  logic                  iss_en,
   input  logic [ADDR_W-1:0]     iss_addr,
   input  logic                  clr_req,
   output logic                  clr_busy
);
   localparam int NREGS = 2**ADDR_W;
   typedef enum logic {IDLE, CLEAR} state_t;
   state_t state, state_nx;
   logic [ADDR_W-1:0] ptr, ptr_nx;
   logic [DATA_W-1:0] regs [NREGS];
   logic [NREGS-1:0]  pend;
   always_comb begin
      state_nx = state;
      ptr_nx   = ptr;
      if (state == IDLE) begin
         if (clr_req) begin
            state_nx = CLEAR;
            ptr_nx   = ADDR_W'(1);
         end
      end else begin
         ptr_nx = ptr + 1'b1;
         if (&ptr) state_nx = IDLE;
      end
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= IDLE;
         ptr   <= '0;
      end else begin
         state <= state_nx;
         ptr   <= ptr_nx;
      end
   end
   // issue is applied after writeback so a same-cycle newer producer keeps pend set
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NREGS; i++) regs[i] <= '0;
         pend <= '0;
      end else if (state == CLEAR) begin
         regs[ptr] <= '0;
         pend[ptr] <= 1'b0;
      end else begin
         if (wr_en && wr_addr != '0) begin
            regs[wr_addr] <= wr_data;
            pend[wr_addr] <= 1'b0;
         end
         if (iss_en && iss_addr != '0) pend[iss_addr] <= 1'b1;
      end
   end
   assign clr_busy = (state == CLEAR);
   for (genvar k = 0; k < NRD; k++) begin : g_rd
      logic [ADDR_W-1:0] a;
      logic byp;
      assign a   = rd_addr[k*ADDR_W +: ADDR_W];
      assign byp = wr_en && wr_addr == a && state == IDLE;
      assign rd_data[k*DATA_W +: DATA_W] = (!rst || a == '0) ? '0 : byp ? wr_data : regs[a];
      assign rd_busy[k] = rst && a != '0 && !byp && pend[a];
   end
endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: randomized and directed checks of regfile_sb (default and 32/3/3 instances) against a behavioural model
module tb_regfile_sb;
   logic clk = 0, rst = 0, sel = 0;
   logic [3:0] ra [3];
   logic we = 0, ie = 0, cr = 0;
   logic [3:0] wa = 0, ia = 0;
   logic [31:0] wd = 0;
   logic [31:0] a_rd_data;
   logic [1:0]  a_rd_busy;
   logic        a_clr_busy;
   logic [95:0] b_rd_data;
   logic [2:0]  b_rd_busy;
   logic        b_clr_busy;
   int n_cmp = 0, n_err = 0;
   logic [31:0] mm [16];
   bit          mp [16];
   int          clr_left = 0;

   always #5 clk = ~clk;

   regfile_sb u_a (
      .clk(clk), .rst(rst), .rd_addr({ra[1], ra[0]}), .rd_data(a_rd_data), .rd_busy(a_rd_busy),
      .wr_en(we & ~sel), .wr_addr(wa), .wr_data(wd[15:0]), .iss_en(ie & ~sel), .iss_addr(ia),
      .clr_req(cr & ~sel), .clr_busy(a_clr_busy));

   regfile_sb #(.DATA_W(32), .ADDR_W(3), .NRD(3)) u_b (
      .clk(clk), .rst(rst), .rd_addr({ra[2][2:0], ra[1][2:0], ra[0][2:0]}), .rd_data(b_rd_data),
      .rd_busy(b_rd_busy), .wr_en(we & sel), .wr_addr(wa[2:0]), .wr_data(wd), .iss_en(ie & sel),
      .iss_addr(ia[2:0]), .clr_req(cr & sel), .clr_busy(b_clr_busy));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic int nregs(); return sel ? 8 : 16; endfunction
   function automatic int nrd(); return sel ? 3 : 2; endfunction
   function automatic logic [31:0] dmask(); return sel ? 32'hFFFF_FFFF : 32'h0000_FFFF; endfunction

   function automatic logic [31:0] got_d(input int k);
      if (sel) return b_rd_data[k*32 +: 32];
      return {16'h0, a_rd_data[k*16 +: 16]};
   endfunction
   function automatic logic got_b(input int k);
      return sel ? b_rd_busy[k] : a_rd_busy[k];
   endfunction

   function automatic logic [31:0] exp_d(input int k);
      if (ra[k] == 0) return 0;
      if (clr_left == 0 && we && wa == ra[k]) return wd & dmask();
      return mm[ra[k]];
   endfunction
   function automatic logic exp_b(input int k);
      if (ra[k] == 0) return 0;
      if (clr_left == 0 && we && wa == ra[k]) return 0;
      return mp[ra[k]];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 16; i++) begin mm[i] = 0; mp[i] = 0; end
      clr_left = 0;
   endtask

   task automatic step();
      if (clr_left > 0) begin
         mm[nregs() - clr_left] = 0;
         mp[nregs() - clr_left] = 0;
         clr_left--;
      end else begin
         if (we && wa != 0) begin mm[wa] = wd & dmask(); mp[wa] = 0; end
         if (ie && ia != 0) mp[ia] = 1;
         if (cr) clr_left = nregs() - 1;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      for (int k = 0; k < nrd(); k++) begin
         chk($sformatf("data%0d", k), got_d(k), exp_d(k));
         chk($sformatf("busy%0d", k), got_b(k), exp_b(k));
      end
      chk("clr_busy", sel ? b_clr_busy : a_clr_busy, clr_left > 0);
      @(posedge clk);
      step();
      #1;
   endtask

   task automatic rand_cycles(input int n);
      for (int c = 0; c < n; c++) begin
         we = $urandom_range(0, 1);
         ie = $urandom_range(0, 2) == 0;
         cr = $urandom_range(0, 40) == 0;
         wa = 4'($urandom_range(0, nregs() - 1));
         ia = 4'($urandom_range(0, nregs() - 1));
         wd = $urandom;
         for (int k = 0; k < 3; k++) ra[k] = 4'($urandom_range(0, nregs() - 1));
         if ($urandom_range(0, 3) == 0) ra[0] = wa;
         tick();
      end
      we = 0; ie = 0; cr = 0;
   endtask

   task automatic count_clear(input string tag, input int exp);
      int n = 0;
      while ((sel ? b_clr_busy : a_clr_busy) && n < 40) begin
         if (!sel && n == 2) chk("r3_pre_clear", a_rd_data[15:0] != 0, 1);
         if (!sel && n == 3) chk("r3_post_clear", a_rd_data[15:0], 0);
         we = !sel && n == 5; wa = 2; wd = 32'hAAAA;
         tick();
         n++;
      end
      we = 0;
      chk(tag, n, exp);
   endtask

   initial begin
      for (int k = 0; k < 3; k++) ra[k] = 0;
      model_reset();
      repeat (2) @(posedge clk);
      #1 chk("in_reset", {a_rd_data, a_rd_busy, a_clr_busy}, 0);
      rst = 1;
      for (int a = 0; a < 16; a++) begin
         ra[0] = 4'(a); ra[1] = 4'(15 - a);
         tick();
         chk("reset_read", {a_rd_data, a_rd_busy}, 0);
      end
      we = 1; wa = 0; wd = 32'hFFFF; ra[0] = 0;
      tick();
      we = 0;
      #1 chk("r0_zero", a_rd_data[15:0], 0);
      we = 1; wa = 5; wd = 32'hBEEF; ra[0] = 5;
      #1 chk("bypass", {a_rd_busy[0], a_rd_data[15:0]}, 17'h0BEEF);
      tick();
      we = 0;
      #1 chk("stored_r5", a_rd_data[15:0], 16'hBEEF);
      ie = 1; ia = 7; ra[0] = 7;
      #1 chk("issue_same_cycle", a_rd_busy[0], 0);
      tick();
      ie = 0;
      #1 chk("issue_busy", a_rd_busy[0], 1);
      we = 1; wa = 7; wd = 32'h1234;
      #1 chk("wb_bypass", {a_rd_busy[0], a_rd_data[15:0]}, 17'h01234);
      tick();
      we = 0;
      #1 chk("wb_done", {a_rd_busy[0], a_rd_data[15:0]}, 17'h01234);
      we = 1; ie = 1; wa = 7; ia = 7; wd = 32'h5678;
      tick();
      we = 0; ie = 0;
      #1 chk("iss_and_wb", {a_rd_busy[0], a_rd_data[15:0]}, 17'h15678);
      for (int i = 1; i < 16; i++) begin
         we = 1; wa = 4'(i); wd = 32'(i * 16'h1111);
         tick();
      end
      we = 0; ra[0] = 3; ra[1] = 2;
      cr = 1;
      tick();
      cr = 0;
      count_clear("clr_len_16", 15);
      chk("r2_dropped", a_rd_data[31:16], 0);
      we = 1; wa = 9; wd = 32'h9999;
      tick();
      we = 0; ra[1] = 9;
      #1 chk("write_after_clear", a_rd_data[31:16], 16'h9999);
      rand_cycles(300);
      cr = 1;
      tick();
      cr = 0;
      repeat (5) tick();
      chk("in_clear", a_clr_busy, 1);
      we = 1; wa = 5; wd = 32'h1111; ra[0] = 5; ra[1] = 9;
      #1 rst = 0;
      #1 chk("async_reset", {a_rd_data, a_rd_busy, a_clr_busy}, 0);
      model_reset();
      @(negedge clk);
      #1 rst = 1;
      @(posedge clk);
      step();
      #1 we = 0;
      #1 chk("post_reset_wr", a_rd_data, 32'h0000_1111);
      sel = 1;
      model_reset();
      rand_cycles(50);
      while (clr_left > 0) tick();
      cr = 1;
      tick();
      cr = 0;
      count_clear("clr_len_8", 7);
      rand_cycles(400);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
